// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: tracks E/M/W destination registers and remaining Tnew, plus the HI/LO busy counter.
// Define HAZARD_FWD_EN to enable forwarding selects; undefined, any hit on a read source stalls.
module hazard_scoreboard #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] d_rs,
   input  logic [4:0] d_rt,
   input  logic [2:0] d_tuse_rs,
   input  logic [2:0] d_tuse_rt,
   input  logic [4:0] d_a3,
   input  logic       d_rwnz,
   input  logic [2:0] d_tnew,
   input  logic       d_md_start,
   input  logic       d_md_div,
   input  logic       d_md_use,
   input  logic       flush,
   output logic       stall,
   output logic [1:0] fwd_rs,
   output logic [1:0] fwd_rt,
   output logic       md_busy
);

   localparam int CNT_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);

   logic          e_valid, m_valid, w_valid;
   logic [4:0]    e_a3, m_a3, w_a3;
   logic [2:0]    e_tnew, m_tnew, w_tnew;
   logic          e_md, e_md_div;
   logic [CW-1:0] busy_cnt;

   logic          rs_read, rt_read;
   logic [2:0]    rs_hit, rt_hit;
   logic          rs_stall, rt_stall, md_stall;

   // Hit vectors are ordered {E, M, W}; the youngest hit wins.
   assign rs_read = (d_rs != 5'd0) && (d_tuse_rs != 3'd7);
   assign rt_read = (d_rt != 5'd0) && (d_tuse_rt != 3'd7);
   assign rs_hit  = {rs_read && e_valid && (e_a3 == d_rs),
                     rs_read && m_valid && (m_a3 == d_rs),
                     rs_read && w_valid && (w_a3 == d_rs)};
   assign rt_hit  = {rt_read && e_valid && (e_a3 == d_rt),
                     rt_read && m_valid && (m_a3 == d_rt),
                     rt_read && w_valid && (w_a3 == d_rt)};

`ifdef HAZARD_FWD_EN
   // Returns {stall, fwd_code} from the youngest hitting stage.
   function automatic logic [2:0] pick(input logic [2:0] hit, input logic [2:0] tuse,
                                       input logic [2:0] te, input logic [2:0] tm,
                                       input logic [2:0] tw);
      logic [2:0] res;
      res = 3'd0;
      if (hit[2])
         res = {te > tuse, (te == 3'd0) ? 2'd1 : 2'd0};
      else if (hit[1])
         res = {tm > tuse, (tm == 3'd0) ? 2'd2 : 2'd0};
      else if (hit[0])
         res = {tw > tuse, (tw == 3'd0) ? 2'd3 : 2'd0};
      return res;
   endfunction

   assign {rs_stall, fwd_rs} = pick(rs_hit, d_tuse_rs, e_tnew, m_tnew, w_tnew);
   assign {rt_stall, fwd_rt} = pick(rt_hit, d_tuse_rt, e_tnew, m_tnew, w_tnew);
`else
   logic unused_w_tnew;

   assign rs_stall      = |rs_hit;
   assign rt_stall      = |rt_hit;
   assign fwd_rs        = 2'd0;
   assign fwd_rt        = 2'd0;
   assign unused_w_tnew = ^w_tnew;
`endif

   // An md op issued last cycle has not loaded the counter yet, so e_md covers that gap.
   assign md_stall = d_md_use && ((busy_cnt != '0) || e_md);
   assign stall    = rs_stall | rt_stall | md_stall;
   assign md_busy  = (busy_cnt != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_valid  <= 1'b0;
         e_a3     <= 5'd0;
         e_tnew   <= 3'd0;
         m_valid  <= 1'b0;
         m_a3     <= 5'd0;
         m_tnew   <= 3'd0;
         w_valid  <= 1'b0;
         w_a3     <= 5'd0;
         w_tnew   <= 3'd0;
         e_md     <= 1'b0;
         e_md_div <= 1'b0;
         busy_cnt <= '0;
      end else begin
         w_valid <= m_valid;
         w_a3    <= m_a3;
         w_tnew  <= m_tnew;

         if (flush) begin
            m_valid <= 1'b0;
            m_a3    <= 5'd0;
            m_tnew  <= 3'd0;
         end else begin
            m_valid <= e_valid;
            m_a3    <= e_a3;
            m_tnew  <= (e_tnew == 3'd0) ? 3'd0 : e_tnew - 3'd1;
         end

         if (!stall && !flush) begin
            e_valid <= d_rwnz && (d_a3 != 5'd0);
            e_a3    <= d_a3;
            e_tnew  <= d_tnew;
         end else begin
            e_valid <= 1'b0;
            e_a3    <= 5'd0;
            e_tnew  <= 3'd0;
         end

         e_md     <= d_md_start && !stall && !flush;
         e_md_div <= d_md_div;

         // A flushed md op in E is killed before it can start the unit.
         if (e_md && !flush)
            busy_cnt <= e_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
         else if (busy_cnt != '0)
            busy_cnt <= busy_cnt - CW'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow the HAZARD_FWD_EN build setting.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] d_rs, d_rt, d_a3;
   logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
   logic       d_rwnz, d_md_start, d_md_div, d_md_use, flush;
   logic       stall, md_busy;
   logic [1:0] fwd_rs, fwd_rt;

   logic [5:0] exp_q[$];
   string      name_q[$];
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk(clk), .reset(reset),
      .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
      .d_a3(d_a3), .d_rwnz(d_rwnz), .d_tnew(d_tnew),
      .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
      .flush(flush), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy)
   );

   task automatic idle();
      d_rs = 5'd0;  d_rt = 5'd0;  d_tuse_rs = 3'd7;  d_tuse_rt = 3'd7;
      d_a3 = 5'd0;  d_rwnz = 1'b0;  d_tnew = 3'd0;
      d_md_start = 1'b0;  d_md_div = 1'b0;  d_md_use = 1'b0;  flush = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic producer(input logic [4:0] a3, input logic [2:0] tnew);
      d_a3 = a3;  d_rwnz = 1'b1;  d_tnew = tnew;
   endtask

   task automatic read_rs(input logic [4:0] r, input logic [2:0] tuse);
      d_rs = r;  d_tuse_rs = tuse;
   endtask

   task automatic read_rt(input logic [4:0] r, input logic [2:0] tuse);
      d_rt = r;  d_tuse_rt = tuse;
   endtask

   // st_f/frs/frt apply with forwarding built in; st_n is the stall without it.
   task automatic expect_out(input string name, input logic st_f, input logic [1:0] frs,
                             input logic [1:0] frt, input logic st_n, input logic busy);
`ifdef HAZARD_FWD_EN
      exp_q.push_back({st_f, frs, frt, busy});
`else
      exp_q.push_back({st_n, 2'd0, 2'd0, busy});
`endif
      name_q.push_back(name);
   endtask

   // Monitor: compares pending expectations mid-cycle, or right after an async reset.
   initial begin
      logic [5:0] got, want;
      string      nm;
      forever begin
         @(negedge clk or posedge reset);
         #1;
         while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            got  = {stall, fwd_rs, fwd_rt, md_busy};
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL %s: got stall=%0b fwd_rs=%0d fwd_rt=%0d md_busy=%0b, expected stall=%0b fwd_rs=%0d fwd_rt=%0d md_busy=%0b",
                        nm, got[5], got[4:3], got[2:1], got[0], want[5], want[4:3], want[2:1], want[0]);
            end
         end
      end
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      idle();
      reset = 1'b1;
      @(posedge clk);
      #1;
      expect_out("reset_hold", 0, 0, 0, 0, 0);
      tick(); reset = 1'b0;
      expect_out("after_reset", 0, 0, 0, 0, 0);

      // addu $1 (tnew=1) then a reader of $1 with tuse=1
      tick(); producer(5'd1, 3'd1);      expect_out("addu_prod", 0, 0, 0, 0, 0);
      tick(); read_rs(5'd1, 3'd1);       expect_out("addu_use_e", 0, 0, 0, 1, 0);
      tick(); read_rs(5'd1, 3'd1);       expect_out("addu_use_m", 0, 2, 0, 1, 0);
      tick(); read_rs(5'd1, 3'd1);       expect_out("addu_use_w", 0, 3, 0, 1, 0);
      tick(); read_rs(5'd1, 3'd1);       expect_out("addu_use_clear", 0, 0, 0, 0, 0);

      // lw $2 (tnew=2) then beq on $2 (tuse=0)
      tick(); producer(5'd2, 3'd2);      expect_out("lw_prod", 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick(); read_rs(5'd2, 3'd0); read_rt(5'd0, 3'd0);
         case (i)
            0, 1:    expect_out("load_use_stall", 1, 0, 0, 1, 0);
            2:       expect_out("load_use_w", 0, 3, 0, 1, 0);
            default: expect_out("load_use_clear", 0, 0, 0, 0, 0);
         endcase
      end

      // writes to $0 never register
      tick(); d_a3 = 5'd0; d_tnew = 3'd1; expect_out("zero_prod", 0, 0, 0, 0, 0);
      tick(); read_rs(5'd0, 3'd0); read_rt(5'd0, 3'd0);
      expect_out("zero_use", 0, 0, 0, 0, 0);

      // tnew=0 producer on rt; M copy must stay at 0 rather than wrap
      tick(); producer(5'd5, 3'd0);      expect_out("rt_prod", 0, 0, 0, 0, 0);
      tick(); read_rt(5'd5, 3'd0); d_rs = 5'd5;
      expect_out("rt_fwd_e", 0, 0, 1, 1, 0);
      tick(); read_rt(5'd5, 3'd0);       expect_out("rt_fwd_m_sat", 0, 0, 2, 1, 0);
      tick();                            expect_out("rt_idle", 0, 0, 0, 0, 0);

      // div, then mflo one cycle later
      tick(); d_md_start = 1'b1; d_md_div = 1'b1;
      expect_out("div_issue", 0, 0, 0, 0, 0);
      tick(); d_md_use = 1'b1; producer(5'd8, 3'd1);
      expect_out("mflo_e_md", 1, 0, 0, 1, 0);
      for (int i = 0; i < 10; i++) begin
         tick(); d_md_use = 1'b1; producer(5'd8, 3'd1);
         expect_out("mflo_busy", 1, 0, 0, 1, 1);
      end
      tick(); d_md_use = 1'b1; producer(5'd8, 3'd1);
      expect_out("mflo_release", 0, 0, 0, 0, 0);
      repeat (3) tick();

      // lw $3 killed by flush in E
      tick(); producer(5'd3, 3'd2);      expect_out("flush_prod", 0, 0, 0, 0, 0);
      tick(); flush = 1'b1;              expect_out("flush_edge", 0, 0, 0, 0, 0);
      tick(); read_rs(5'd3, 3'd0);       expect_out("flush_use", 0, 0, 0, 0, 0);

      // flush coinciding with a data stall bubbles both E and M
      tick(); producer(5'd4, 3'd1);      expect_out("fs_prod", 0, 0, 0, 0, 0);
      tick(); read_rs(5'd4, 3'd0); producer(5'd6, 3'd1); flush = 1'b1;
      expect_out("fs_both", 1, 0, 0, 1, 0);
      tick(); read_rs(5'd4, 3'd0); producer(5'd6, 3'd1);
      expect_out("fs_after", 0, 0, 0, 0, 0);

      // fill E/M/W and run the divider down to 7, then reset asynchronously
      tick(); d_md_start = 1'b1; d_md_div = 1'b1; producer(5'd10, 3'd1);
      expect_out("rst_div", 0, 0, 0, 0, 0);
      tick(); producer(5'd11, 3'd1);     expect_out("rst_fill1", 0, 0, 0, 0, 0);
      tick(); producer(5'd12, 3'd2);     expect_out("rst_fill2", 0, 0, 0, 0, 1);
      tick(); producer(5'd13, 3'd1);     expect_out("rst_fill3", 0, 0, 0, 0, 1);
      tick(); producer(5'd14, 3'd1);     expect_out("rst_fill4", 0, 0, 0, 0, 1);
      tick(); read_rs(5'd14, 3'd0);      expect_out("rst_pre", 1, 0, 0, 1, 1);
      @(negedge clk);
      #2;
      reset = 1'b1;
      expect_out("reset_async", 0, 0, 0, 0, 0);
      tick(); reset = 1'b0;              expect_out("reset_next", 0, 0, 0, 0, 0);
      tick(); read_rs(5'd14, 3'd0); d_md_use = 1'b1;
      expect_out("reset_empty", 0, 0, 0, 0, 0);
      tick();

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations never compared, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
